// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides: frame state
// encoding, character width and default bit timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;   // 50 MHz / 115200

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO. Full/empty come from the occupancy count, so the
// pointers simply wrap modulo DEPTH (DEPTH must be a power of two).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head is read combinationally so the consumer can load it on the pop edge.
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a valid/ready byte FIFO. Frames are sent back
// to back: the next byte is popped on the last stop-bit cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         uart_txd,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   baud_last;

    // Ready depends only on the registered count; no path from tx_valid.
    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle is derived from the next state so the
    // pin itself is a plain flop.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign uart_txd = txd_q;
    assign tx_busy  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame model checked every cycle, a
// mid-bit sampling receiver for byte order, and hand-computed frame checks.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int CB    = 434;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, uart_txd, tx_busy;
    logic [2:0] fifo_count;

    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready, b_txd, b_busy;
    logic [2:0] b_count;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CB), .FIFO_DEPTH(DEPTH), .DATA_BITS(8)) dut_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (b_data),
        .tx_valid   (b_valid),
        .tx_ready   (b_ready),
        .uart_txd   (b_txd),
        .tx_busy    (b_busy),
        .fifo_count (b_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: queued bytes plus the frame currently on the line.
    byte unsigned m_q[$];
    bit           m_active = 1'b0;
    int           m_t = 0;
    logic [7:0]   m_shift = '0;
    int           m_pushes = 0;

    // Accepted bytes awaiting the reference receiver.
    byte unsigned sb[$];
    bit           rx_busy = 1'b0;
    int           rx_cnt = 0;
    logic [7:0]   rx_byte = '0;
    logic [7:0]   rx_last = '0;
    int           rx_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_shift[k-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        int pre;
        bit push;
        pre  = m_q.size();
        push = (tx_valid === 1'b1) && (pre != DEPTH);
        if (!m_active) begin
            if (pre > 0) begin
                m_shift  = m_q.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
        end else begin
            m_t++;
            if (m_t == 10 * C) begin
                m_t = 0;
                if (pre > 0) m_shift = m_q.pop_front();
                else         m_active = 1'b0;
            end
        end
        if (push) begin
            m_q.push_back(tx_data);
            sb.push_back(tx_data);
            m_pushes++;
        end
    endtask

    task automatic rx_step();
        if (!rx_busy) begin
            if (uart_txd === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % C) == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
                rx_byte[rx_cnt/C-1] = uart_txd;
            if (rx_cnt == 9 * C + C / 2) begin
                rx_busy = 1'b0;
                chk("rx_stop_bit", uart_txd, 1);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected_frame: got %0h, expected no frame at %0t", rx_byte, $time);
                end else begin
                    chk("rx_byte_order", rx_byte, sb.pop_front());
                end
                rx_last = rx_byte;
                rx_frames++;
            end
        end
    endtask

    // Every-cycle comparison against the model; model then advances over the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_txd", uart_txd, 1);
            chk("rst_ready", tx_ready, 1);
            chk("rst_busy", tx_busy, 0);
            chk("rst_count", fifo_count, 0);
            m_q.delete();
            sb.delete();
            m_active = 1'b0;
            m_t      = 0;
            rx_busy  = 1'b0;
            rx_cnt   = 0;
        end else begin
            chk("txd", uart_txd, exp_txd());
            chk("fifo_count", fifo_count, m_q.size());
            chk("tx_ready", tx_ready, (m_q.size() != DEPTH) ? 1 : 0);
            chk("tx_busy", tx_busy, (m_active || m_q.size() != 0) ? 1 : 0);
            rx_step();
            model_step();
        end
    end

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!tx_busy) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle_timeout: got busy, expected idle within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish by 2 ms");
        $fatal(1, "watchdog");
    end

    logic [9:0] pat55;
    logic [9:0] pat81;
    logic [7:0] big_byte;
    int         f0, p0, accepted, guard, pos, bidx;
    logic       r;
    bit         full_seen;

    initial begin
        pat55    = 10'b10_1010_1010;
        pat81    = 10'b11_0000_0010;
        big_byte = '0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        b_valid  = 1'b0;
        b_data   = '0;

        // Reset values of both instances
        repeat (3) @(negedge clk);
        chk("big_rst_txd", b_txd, 1);
        chk("big_rst_ready", b_ready, 1);
        chk("big_rst_busy", b_busy, 0);
        chk("big_rst_count", b_count, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk("idle_txd", uart_txd, 1);
        end

        // Single byte 0x55
        @(posedge clk); #1; tx_valid = 1'b1; tx_data = 8'h55;
        @(posedge clk); #1; tx_valid = 1'b0;
        @(negedge clk);
        chk("t55_count_after_push", fifo_count, 1);
        chk("t55_busy_after_push", tx_busy, 1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("t55_frame_bit", uart_txd, pat55[k/4]);
            if (k == 39) chk("t55_busy_last_stop", tx_busy, 1);
        end
        @(negedge clk);
        chk("t55_busy_fall", tx_busy, 0);
        chk("t55_txd_idle", uart_txd, 1);
        chk("t55_rx", rx_last, 8'h55);
        @(posedge clk); #1;

        // Back-to-back 0xA3, 0x0F, 0xFF
        f0 = rx_frames;
        tx_valid = 1'b1; tx_data = 8'hA3;
        @(posedge clk); #1; tx_data = 8'h0F;
        @(negedge clk); chk("b2b_count1", fifo_count, 1);
        @(posedge clk); #1; tx_data = 8'hFF;
        @(negedge clk); chk("b2b_count2", fifo_count, 1);
        @(posedge clk); #1; tx_valid = 1'b0;
        @(negedge clk); chk("b2b_count3", fifo_count, 2);
        repeat (38) @(negedge clk);
        chk("b2b_stop_level", uart_txd, 1);
        chk("b2b_count_before_pop", fifo_count, 2);
        @(negedge clk);
        chk("b2b_no_gap_start", uart_txd, 0);
        chk("b2b_count_after_pop", fifo_count, 1);
        wait_idle(400);
        chk("b2b_frames", rx_frames - f0, 3);
        chk("b2b_last_byte", rx_last, 8'hFF);

        // Backpressure with tx_valid held high for 20 accepts
        f0 = rx_frames;
        accepted  = 0;
        guard     = 0;
        full_seen = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'($urandom);
        while (accepted < 20 && guard < 3000) begin
            @(negedge clk);
            r = tx_ready;
            if (accepted == 5 && !full_seen) begin
                full_seen = 1'b1;
                chk("full_ready_low", tx_ready, 0);
                chk("full_count", fifo_count, 4);
            end
            @(posedge clk); #1;
            if (r) begin
                accepted++;
                tx_data = 8'($urandom);
            end
            guard++;
        end
        tx_valid = 1'b0;
        chk("full_accepts", accepted, 20);
        wait_idle(2000);
        chk("full_frames", rx_frames - f0, 20);

        // Reset during DATA bit 3 of 0x00 with two more bytes queued
        tx_valid = 1'b1; tx_data = 8'h00;
        @(posedge clk); #1; tx_data = 8'h11;
        @(posedge clk); #1; tx_data = 8'h22;
        @(posedge clk); #1; tx_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("mid_txd_before_rst", uart_txd, 0);
        #1; rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_idle", uart_txd, 1);
        end
        @(posedge clk); #1;
        f0 = rx_frames;
        tx_valid = 1'b1; tx_data = 8'hC6;
        @(posedge clk); #1; tx_valid = 1'b0;
        wait_idle(200);
        chk("post_rst_frames", rx_frames - f0, 1);
        chk("post_rst_byte", rx_last, 8'hC6);

        // Random traffic
        f0 = rx_frames;
        p0 = m_pushes;
        for (int i = 0; i < 300; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        wait_idle(2000);
        chk("rand_frames", rx_frames - f0, m_pushes - p0);
        chk("rand_sb_empty", sb.size(), 0);

        // Large divider, byte 0x81
        b_valid = 1'b1; b_data = 8'h81;
        @(posedge clk); #1; b_valid = 1'b0;
        @(negedge clk);
        chk("big_count_after_push", b_count, 1);
        chk("big_txd_before_start", b_txd, 1);
        for (int k = 0; k < 10 * CB; k++) begin
            @(negedge clk);
            pos  = k % CB;
            bidx = k / CB;
            if (pos == 0 || pos == CB / 2 || pos == CB - 1)
                chk("big_bit_level", b_txd, pat81[bidx]);
            if (pos == CB / 2 && bidx >= 1 && bidx <= 8)
                big_byte[bidx-1] = b_txd;
        end
        @(negedge clk);
        chk("big_busy_fall", b_busy, 0);
        chk("big_txd_idle", b_txd, 1);
        chk("big_rx_byte", big_byte, 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
